// File: rtl/level_status_ctrl.sv
// level_status_ctrl: tracks level and lives from game events and holds reset_level
// high for a frame-counted pause after each event, or indefinitely at game over.
module level_status_ctrl #(
    parameter int HOLD_FRAMES = 60,
    parameter int MAX_LEVEL   = 4,
    parameter int LIVES_INIT  = 3,
    localparam int LW = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1,
    localparam int CW = $clog2(HOLD_FRAMES + 1)
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          startOfFrame,
    input  logic          ball_lost,
    input  logic          level_done,
    input  logic          new_game,
    output logic          reset_level,
    output logic [LW-1:0] level,
    output logic [2:0]    lives,
    output logic          game_over
);
    typedef enum logic [1:0] {PLAY, HOLD_LEVEL, HOLD_LOST, GAME_OVER} state_t;
    state_t        state_q, state_d;
    logic [LW-1:0] level_q, level_d;
    logic [2:0]    lives_q, lives_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rl_q, go_q;
    logic          hold_end;
    assign hold_end = cnt_q == CW'(HOLD_FRAMES - 1);
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        if (new_game) begin
            state_d = PLAY;
            level_d = '0;
            lives_d = 3'(LIVES_INIT);
            cnt_d   = '0;
        end else begin
            case (state_q)
                PLAY: begin
                    // level_done wins over a simultaneous ball_lost: no life is lost
                    if (level_done) begin
                        state_d = HOLD_LEVEL;
                        level_d = (level_q == LW'(MAX_LEVEL - 1)) ? '0 : level_q + LW'(1);
                        cnt_d   = '0;
                    end else if (ball_lost && lives_q != 3'd0) begin
                        lives_d = lives_q - 3'd1;
                        state_d = (lives_q == 3'd1) ? GAME_OVER : HOLD_LOST;
                        cnt_d   = '0;
                    end
                end
                HOLD_LEVEL, HOLD_LOST: begin
                    if (startOfFrame) begin
                        state_d = hold_end ? PLAY : state_q;
                        cnt_d   = hold_end ? '0 : cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= PLAY;
            level_q <= '0;
            lives_q <= 3'(LIVES_INIT);
            cnt_q   <= '0;
            rl_q    <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
            rl_q    <= state_d != PLAY;
            go_q    <= state_d == GAME_OVER;
        end
    end
    assign reset_level = rl_q;
    assign level       = level_q;
    assign lives       = lives_q;
    assign game_over   = go_q;
endmodule
